// File: rtl/seg7_scan_decoder.sv
// Multiplexed 7-segment display snooper: synchronizes the segment and digit
// lines of a scanned display, waits for each digit to dwell long enough to be
// trusted, decodes it to a hex nibble and publishes whole frames at once.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic [6:0]              iSEG,
    input  logic [NUM_DIGITS-1:0]   iDIG_N,
    output logic [4*NUM_DIGITS-1:0] oVALUE,
    output logic                    oVALID,
    output logic [NUM_DIGITS-1:0]   oBLANK,
    output logic [NUM_DIGITS-1:0]   oINVALID,
    output logic                    oSELERR
);

    localparam int                    IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0]            CNT_MAX   = 8'(STABLE_CYCLES);
    localparam logic [7:0]            CNT_CAP   = 8'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] MASK_FULL = '1;

    // Returns {invalid, blank, nibble} for an active-high gfedcba pattern.
    function automatic logic [5:0] seg_decode(input logic [6:0] pat);
        logic [5:0] r;
        case (pat)
            7'b0111111: r = {2'b00, 4'h0};
            7'b0000110: r = {2'b00, 4'h1};
            7'b1011011: r = {2'b00, 4'h2};
            7'b1001111: r = {2'b00, 4'h3};
            7'b1100110: r = {2'b00, 4'h4};
            7'b1101101: r = {2'b00, 4'h5};
            7'b1111101: r = {2'b00, 4'h6};
            7'b0000111: r = {2'b00, 4'h7};
            7'b1111111: r = {2'b00, 4'h8};
            7'b1101111: r = {2'b00, 4'h9};
            7'b1110111: r = {2'b00, 4'hA};
            7'b1111100: r = {2'b00, 4'hB};
            7'b0111001: r = {2'b00, 4'hC};
            7'b1011110: r = {2'b00, 4'hD};
            7'b1111001: r = {2'b00, 4'hE};
            7'b1110001: r = {2'b00, 4'hF};
            7'b0000000: r = {2'b01, 4'h0};
            default:    r = {2'b10, 4'h0};
        endcase
        return r;
    endfunction

    // ---- p0/p1: two-flop synchronizer, idle (all ones) out of reset ----
    logic [6:0]            seg_p0, seg_p1;
    logic [NUM_DIGITS-1:0] dig_p0, dig_p1;

    // Double-register the asynchronous display lines.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            seg_p0 <= '1;
            seg_p1 <= '1;
            dig_p0 <= '1;
            dig_p1 <= '1;
        end else begin
            seg_p0 <= iSEG;
            seg_p1 <= seg_p0;
            dig_p0 <= iDIG_N;
            dig_p1 <= dig_p0;
        end
    end

    // ---- p1: synchronized sample -> pattern, select decode, stability ----
    logic [6:0]       pat_p1;
    logic [IDX_W-1:0] sel_idx_p1;
    int               n_low_p1;
    logic             vld_p1, conflict_p1, same_p1, cap_p1;
    logic [5:0]       dec_p1;
    logic [7:0]       cnt_next;

    assign pat_p1 = ~seg_p1;
    assign dec_p1 = seg_decode(pat_p1);

    // Count active enables and remember which one is low.
    always_comb begin
        n_low_p1   = 0;
        sel_idx_p1 = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!dig_p1[k]) begin
                n_low_p1   = n_low_p1 + 1;
                sel_idx_p1 = IDX_W'(k);
            end
        end
    end

    assign vld_p1      = (n_low_p1 == 1);
    assign conflict_p1 = (n_low_p1 > 1);

    // ---- p2: previous-sample state, dwell counter ----
    logic [6:0]       prev_pat_p2;
    logic [IDX_W-1:0] prev_idx_p2;
    logic             prev_vld_p2;
    logic [7:0]       cnt_p2;

    assign same_p1 = vld_p1 && prev_vld_p2 && (sel_idx_p1 == prev_idx_p2) && (pat_p1 == prev_pat_p2);

    // Counter restarts on any disturbance and saturates once the dwell is long enough.
    always_comb begin
        cnt_next = '0;
        if (same_p1)
            cnt_next = (cnt_p2 == CNT_MAX) ? CNT_MAX : cnt_p2 + 8'd1;
    end

    // Reaching CNT_CAP happens once per dwell because the counter then moves past it.
    assign cap_p1 = same_p1 && (cnt_next == CNT_CAP);

    // Track the previous sample and the dwell count.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            prev_pat_p2 <= '0;
            prev_idx_p2 <= '0;
            prev_vld_p2 <= 1'b0;
            cnt_p2      <= '0;
            oSELERR     <= 1'b0;
        end else begin
            prev_pat_p2 <= pat_p1;
            prev_idx_p2 <= sel_idx_p1;
            prev_vld_p2 <= vld_p1;
            cnt_p2      <= cnt_next;
            oSELERR     <= conflict_p1;
        end
    end

    // ---- p2: staging frame and captured mask ----
    logic [4*NUM_DIGITS-1:0] stage_value_p2;
    logic [NUM_DIGITS-1:0]   stage_blank_p2, stage_invalid_p2, mask_p2, cap_bit_p1;

    assign cap_bit_p1 = cap_p1 ? (NUM_DIGITS'(1) << sel_idx_p1) : '0;

    // Write each captured digit into its staging slot.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            stage_value_p2   <= '0;
            stage_blank_p2   <= '0;
            stage_invalid_p2 <= '0;
        end else if (cap_p1) begin
            stage_value_p2[sel_idx_p1*4 +: 4] <= dec_p1[3:0];
            stage_blank_p2[sel_idx_p1]        <= dec_p1[4];
            stage_invalid_p2[sel_idx_p1]      <= dec_p1[5];
        end
    end

    // ---- p3: frame publish; a capture in the publish cycle seeds the next mask ----
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            mask_p2  <= '0;
            oVALUE   <= '0;
            oBLANK   <= '0;
            oINVALID <= '0;
            oVALID   <= 1'b0;
        end else if (mask_p2 == MASK_FULL) begin
            oVALUE   <= stage_value_p2;
            oBLANK   <= stage_blank_p2;
            oINVALID <= stage_invalid_p2;
            oVALID   <= 1'b1;
            mask_p2  <= cap_bit_p1;
        end else begin
            oVALID   <= 1'b0;
            mask_p2  <= mask_p2 | cap_bit_p1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: drives scanned-display waveforms, queues the
// frame each scan should produce and compares every oVALID frame against it.
module tb_seg7_scan_decoder;

    localparam int ND = 4;

    logic            iCLK;
    logic            iRST_N;
    logic [6:0]      iSEG;
    logic [ND-1:0]   iDIG_N;
    logic [4*ND-1:0] oVALUE;
    logic            oVALID;
    logic [ND-1:0]   oBLANK;
    logic [ND-1:0]   oINVALID;
    logic            oSELERR;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  blank;
        logic [3:0]  invalid;
    } frame_t;

    frame_t sb_q[$];
    frame_t exp_f;
    int     checks = 0;
    int     failures = 0;
    int     frames_seen = 0;
    int     selerr_cnt = 0;
    int     selerr_base;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .iSEG     (iSEG),
        .iDIG_N   (iDIG_N),
        .oVALUE   (oVALUE),
        .oVALID   (oVALID),
        .oBLANK   (oBLANK),
        .oINVALID (oINVALID),
        .oSELERR  (oSELERR)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Active-high gfedcba pattern for a hex digit.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;  default: return 7'b1110001;
        endcase
    endfunction

    task automatic scan(input int k, input logic [6:0] pat, input int n);
        iSEG   = ~pat;
        iDIG_N = ~(ND'(1) << k);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic idle(input int n);
        iDIG_N = '1;
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic push(input logic [15:0] v, input logic [3:0] b, input logic [3:0] i);
        frame_t f;
        f.value = v; f.blank = b; f.invalid = i;
        sb_q.push_back(f);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_value"},   32'(oVALUE),   32'h0);
        chk({tag, "_valid"},   32'(oVALID),   32'h0);
        chk({tag, "_blank"},   32'(oBLANK),   32'h0);
        chk({tag, "_invalid"}, 32'(oINVALID), 32'h0);
        chk({tag, "_selerr"},  32'(oSELERR),  32'h0);
    endtask

    // Output monitor: score every published frame and count conflict pulses.
    always @(negedge iCLK) begin
        if (iRST_N) begin
            if (oSELERR) selerr_cnt++;
            if (oVALID) begin
                frames_seen++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", 32'(oVALUE), 32'hFFFF_FFFF);
                end else begin
                    exp_f = sb_q.pop_front();
                    chk("frame_value",   32'(oVALUE),   32'(exp_f.value));
                    chk("frame_blank",   32'(oBLANK),   32'(exp_f.blank));
                    chk("frame_invalid", 32'(oINVALID), 32'(exp_f.invalid));
                end
            end
        end
    end

    initial begin
        iRST_N = 1'b0;
        iSEG   = '1;
        iDIG_N = '1;
        repeat (3) @(posedge iCLK);
        #1;
        chk_outputs_zero("reset");
        iRST_N = 1'b1;
        idle(5);

        // Plain scan 1,2,3,4.
        push(16'h4321, 4'b0000, 4'b0000);
        for (int k = 0; k < 4; k++) scan(k, seg_of(4'(k + 1)), 10);
        idle(10);
        chk("frames_after_1234", frames_seen, 1);
        chk("hold_4321", 32'(oVALUE), 32'h4321);

        // Short dwell on digit 2 must not capture.
        scan(0, seg_of(4'h5), 10);
        scan(1, seg_of(4'h6), 10);
        scan(2, seg_of(4'h7), 3);
        scan(3, seg_of(4'h8), 10);
        idle(10);
        chk("no_frame_short_dwell", frames_seen, 1);
        push(16'h8765, 4'b0000, 4'b0000);
        scan(2, seg_of(4'h7), 10);
        idle(10);
        chk("frame_after_redwell", frames_seen, 2);

        // Blank and invalid patterns.
        push(16'h0808, 4'b0010, 4'b1000);
        scan(0, seg_of(4'h8), 10);
        scan(1, 7'b0000000, 10);
        scan(2, seg_of(4'h8), 10);
        scan(3, 7'b0000001, 10);
        idle(10);
        chk("frames_after_blank", frames_seen, 3);

        // Select conflict for 5 samples mid-scan.
        push(16'hCBA9, 4'b0000, 4'b0000);
        scan(0, seg_of(4'h9), 10);
        scan(1, seg_of(4'hA), 10);
        selerr_base = selerr_cnt;
        iSEG   = ~seg_of(4'h3);
        iDIG_N = 4'b1100;
        repeat (5) @(posedge iCLK);
        #1;
        scan(2, seg_of(4'hB), 10);
        scan(3, seg_of(4'hC), 10);
        idle(10);
        chk("selerr_pulses", selerr_cnt - selerr_base, 5);
        chk("frames_after_conflict", frames_seen, 4);

        // Reset mid-frame discards partial captures.
        scan(0, seg_of(4'h5), 10);
        scan(1, seg_of(4'h5), 10);
        #3 iRST_N = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        repeat (3) @(posedge iCLK);
        #1;
        chk_outputs_zero("in_reset");
        iRST_N = 1'b1;
        push(16'hDCBA, 4'b0000, 4'b0000);
        scan(2, seg_of(4'hC), 10);
        scan(3, seg_of(4'hD), 10);
        idle(10);
        chk("post_reset_no_frame", frames_seen, 4);
        chk("post_reset_hold", 32'(oVALUE), 32'h0);
        scan(0, seg_of(4'hA), 10);
        scan(1, seg_of(4'hB), 10);
        idle(10);
        chk("frames_after_reset", frames_seen, 5);
        chk("hold_dcba", 32'(oVALUE), 32'hDCBA);

        chk("scoreboard_empty", sb_q.size(), 0);
        chk("selerr_total", selerr_cnt, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
